// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one single-ported BRAM-style slave between NumReq requesters.
// One access in flight at a time; the response is held until its owner accepts it.
module bram_port_arbiter #(
    parameter int NumReq      = 2,
    parameter int DataWidth   = 64,
    parameter int AddrWidth   = 13,
    parameter int ReadLatency = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumReq-1:0]               req_valid_i,
    output logic [NumReq-1:0]               req_ready_o,
    input  logic [NumReq-1:0]               req_we_i,
    input  logic [NumReq*DataWidth/8-1:0]   req_wmask_i,
    input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
    input  logic [NumReq*DataWidth-1:0]     req_wdata_i,
    output logic [NumReq-1:0]               resp_valid_o,
    input  logic [NumReq-1:0]               resp_ready_i,
    output logic [DataWidth-1:0]            resp_rdata_o,
    output logic                            bram_en_o,
    output logic                            bram_we_o,
    output logic [DataWidth/8-1:0]          bram_wmask_o,
    output logic [AddrWidth-1:0]            bram_addr_o,
    output logic [DataWidth-1:0]            bram_wdata_o,
    input  logic [DataWidth-1:0]            bram_rdata_i
);

    localparam int IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int StrbW = DataWidth / 8;
    localparam int CntW  = 3;
    // WAIT lasts ReadLatency-1 cycles; the counter holds the remaining cycles minus one.
    localparam logic [CntW-1:0] WaitLoad = CntW'((ReadLatency > 1) ? (ReadLatency - 2) : 0);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumReq - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_n;
    logic [IdxW-1:0]       owner_r;
    logic [IdxW-1:0]       rr_ptr_r;
    logic                  is_write_r;
    logic [CntW-1:0]       wait_cnt_r;
    logic [CntW-1:0]       wait_cnt_n;
    logic [DataWidth-1:0]  resp_rdata_r;

    logic                  grant_valid_s;
    logic [IdxW-1:0]       grant_idx_s;
    logic                  grant_fire_s;
    logic                  hit_s;
    logic                  sel_we_s;
    logic [StrbW-1:0]      sel_wmask_s;
    logic [AddrWidth-1:0]  sel_addr_s;
    logic [DataWidth-1:0]  sel_wdata_s;

    // Round-robin search: first valid requester at distance 1..NumReq from rr_ptr_r.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = {IdxW{1'b0}};
        hit_s         = 1'b0;
        for (int k = 1; k <= NumReq; k++) begin
            for (int i = 0; i < NumReq; i++) begin
                hit_s = !grant_valid_s && req_valid_i[i] &&
                        (((int'(rr_ptr_r) + k) % NumReq) == i);
                grant_idx_s   = hit_s ? IdxW'(i) : grant_idx_s;
                grant_valid_s = grant_valid_s | hit_s;
            end
        end
    end

    assign grant_fire_s = (state_r == IDLE) && grant_valid_s;

    // Select the granted requester's command fields.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_wmask_s = {StrbW{1'b0}};
        sel_addr_s  = {AddrWidth{1'b0}};
        sel_wdata_s = {DataWidth{1'b0}};
        for (int i = 0; i < NumReq; i++) begin
            sel_we_s    = (grant_idx_s == IdxW'(i)) ? req_we_i[i] : sel_we_s;
            sel_wmask_s = (grant_idx_s == IdxW'(i)) ? req_wmask_i[i*StrbW +: StrbW] : sel_wmask_s;
            sel_addr_s  = (grant_idx_s == IdxW'(i)) ? req_addr_i[i*AddrWidth +: AddrWidth] : sel_addr_s;
            sel_wdata_s = (grant_idx_s == IdxW'(i)) ? req_wdata_i[i*DataWidth +: DataWidth] : sel_wdata_s;
        end
    end

    // Next-state and output decode; the slave command is driven in the grant cycle itself.
    always_comb begin
        state_n      = state_r;
        wait_cnt_n   = wait_cnt_r;
        req_ready_o  = {NumReq{1'b0}};
        resp_valid_o = {NumReq{1'b0}};
        bram_en_o    = 1'b0;
        bram_we_o    = 1'b0;
        bram_wmask_o = {StrbW{1'b0}};
        bram_addr_o  = {AddrWidth{1'b0}};
        bram_wdata_o = {DataWidth{1'b0}};
        case (state_r)
            IDLE: begin
                if (grant_valid_s) begin
                    req_ready_o[grant_idx_s] = 1'b1;
                    bram_en_o    = 1'b1;
                    bram_we_o    = sel_we_s;
                    bram_wmask_o = sel_we_s ? sel_wmask_s : {StrbW{1'b0}};
                    bram_addr_o  = sel_addr_s;
                    bram_wdata_o = sel_wdata_s;
                    wait_cnt_n   = WaitLoad;
                    state_n      = (ReadLatency > 1) ? WAIT : CAPT;
                end else begin
                    state_n = IDLE;
                end
            end
            WAIT: begin
                if (wait_cnt_r == {CntW{1'b0}}) begin
                    state_n = CAPT;
                end else begin
                    wait_cnt_n = wait_cnt_r - {{(CntW-1){1'b0}}, 1'b1};
                end
            end
            CAPT: begin
                state_n = RESP;
            end
            RESP: begin
                resp_valid_o[owner_r] = 1'b1;
                if (resp_ready_i[owner_r]) begin
                    state_n = IDLE;
                end else begin
                    state_n = RESP;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, ownership, round-robin pointer and captured response data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            owner_r      <= {IdxW{1'b0}};
            rr_ptr_r     <= LastIdx;
            is_write_r   <= 1'b0;
            wait_cnt_r   <= {CntW{1'b0}};
            resp_rdata_r <= {DataWidth{1'b0}};
        end else begin
            state_r    <= state_n;
            wait_cnt_r <= wait_cnt_n;
            if (grant_fire_s) begin
                owner_r    <= grant_idx_s;
                rr_ptr_r   <= grant_idx_s;
                is_write_r <= sel_we_s;
            end
            // Writes return zero so a stale read value never leaks to another requester.
            if (state_r == CAPT) begin
                resp_rdata_r <= is_write_r ? {DataWidth{1'b0}} : bram_rdata_i;
            end
        end
    end

    assign resp_rdata_o = resp_rdata_r;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: a ReadLatency=1 instance and a ReadLatency=3 instance,
// each driven against a small slave model that presents read data only in its exact latency cycle.
module tb_bram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- instance A: ReadLatency = 1 ----------------
    logic          a_rst;
    logic [1:0]    a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready;
    logic [15:0]   a_req_wmask;
    logic [25:0]   a_req_addr;
    logic [127:0]  a_req_wdata;
    logic [63:0]   a_resp_rdata, a_bram_wdata, a_bram_rdata, a_slave;
    logic          a_bram_en, a_bram_we;
    logic [7:0]    a_bram_wmask;
    logic [12:0]   a_bram_addr;
    logic          a_pv;
    logic [63:0]   a_pd;
    logic [7:0]    a_en_cnt;

    bram_port_arbiter #(.NumReq(2), .DataWidth(64), .AddrWidth(13), .ReadLatency(1)) u_dut_a (
        .clk_i(clk), .rst_i(a_rst),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_we_i(a_req_we),
        .req_wmask_i(a_req_wmask), .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata),
        .resp_valid_o(a_resp_valid), .resp_ready_i(a_resp_ready), .resp_rdata_o(a_resp_rdata),
        .bram_en_o(a_bram_en), .bram_we_o(a_bram_we), .bram_wmask_o(a_bram_wmask),
        .bram_addr_o(a_bram_addr), .bram_wdata_o(a_bram_wdata), .bram_rdata_i(a_bram_rdata)
    );

    always @(posedge clk) begin
        if (a_rst) begin
            a_pv     <= 1'b0;
            a_pd     <= 64'd0;
            a_en_cnt <= 8'd0;
        end else begin
            a_pv     <= a_bram_en && !a_bram_we;
            a_pd     <= a_slave;
            a_en_cnt <= a_en_cnt + (a_bram_en ? 8'd1 : 8'd0);
        end
    end
    assign a_bram_rdata = a_pv ? a_pd : 64'hDEAD_DEAD_DEAD_DEAD;

    // ---------------- instance B: ReadLatency = 3 ----------------
    logic          b_rst;
    logic [1:0]    b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready;
    logic [15:0]   b_req_wmask;
    logic [25:0]   b_req_addr;
    logic [127:0]  b_req_wdata;
    logic [63:0]   b_resp_rdata, b_bram_wdata, b_bram_rdata, b_slave;
    logic          b_bram_en, b_bram_we;
    logic [7:0]    b_bram_wmask;
    logic [12:0]   b_bram_addr;
    logic          b_pv [3];
    logic [63:0]   b_pd [3];

    bram_port_arbiter #(.NumReq(2), .DataWidth(64), .AddrWidth(13), .ReadLatency(3)) u_dut_b (
        .clk_i(clk), .rst_i(b_rst),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_we_i(b_req_we),
        .req_wmask_i(b_req_wmask), .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
        .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready), .resp_rdata_o(b_resp_rdata),
        .bram_en_o(b_bram_en), .bram_we_o(b_bram_we), .bram_wmask_o(b_bram_wmask),
        .bram_addr_o(b_bram_addr), .bram_wdata_o(b_bram_wdata), .bram_rdata_i(b_bram_rdata)
    );

    always @(posedge clk) begin
        if (b_rst) begin
            for (int s = 0; s < 3; s++) begin
                b_pv[s] <= 1'b0;
                b_pd[s] <= 64'd0;
            end
        end else begin
            b_pv[0] <= b_bram_en && !b_bram_we;
            b_pd[0] <= b_slave;
            for (int s = 1; s < 3; s++) begin
                b_pv[s] <= b_pv[s-1];
                b_pd[s] <= b_pd[s-1];
            end
        end
    end
    assign b_bram_rdata = b_pv[2] ? b_pd[2] : 64'hDEAD_DEAD_DEAD_DEAD;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_g;

        a_rst = 1'b1;  b_rst = 1'b1;
        a_req_valid = 2'b00; a_req_we = 2'b00; a_req_wmask = 16'h0; a_req_addr = 26'h0;
        a_req_wdata = 128'h0; a_resp_ready = 2'b00; a_slave = 64'h0;
        b_req_valid = 2'b00; b_req_we = 2'b00; b_req_wmask = 16'h0; b_req_addr = 26'h0;
        b_req_wdata = 128'h0; b_resp_ready = 2'b00; b_slave = 64'h0;

        repeat (3) @(negedge clk);
        check("rst_req_ready",  a_req_ready,  2'b00);
        check("rst_resp_valid", a_resp_valid, 2'b00);
        check("rst_bram_en",    a_bram_en,    1'b0);
        check("rst_resp_rdata", a_resp_rdata, 64'h0);
        check("rst_b_resp_valid", b_resp_valid, 2'b00);
        a_rst = 1'b0;  b_rst = 1'b0;
        @(negedge clk);

        // Single read from requester 0; wmask must be forced to zero on reads.
        a_slave = 64'h0000_0000_1234_5678;
        a_req_addr[12:0] = 13'h0FF8; a_req_wmask[7:0] = 8'hFF; a_req_valid = 2'b01;
        #1;
        check("rd_ready", a_req_ready,  2'b01);
        check("rd_en",    a_bram_en,    1'b1);
        check("rd_we",    a_bram_we,    1'b0);
        check("rd_addr",  a_bram_addr,  13'h0FF8);
        check("rd_wmask", a_bram_wmask, 8'h00);
        @(negedge clk);
        a_req_valid = 2'b00;
        #1;
        check("rd_capt_en",    a_bram_en,    1'b0);
        check("rd_capt_valid", a_resp_valid, 2'b00);
        @(negedge clk);
        check("rd_resp_valid", a_resp_valid, 2'b01);
        check("rd_resp_data",  a_resp_rdata, 64'h0000_0000_1234_5678);
        check("rd_en_pulses",  a_en_cnt,     8'd1);
        a_resp_ready = 2'b01;
        @(negedge clk);
        a_resp_ready = 2'b00;
        check("rd_resp_done", a_resp_valid, 2'b00);

        // Write from requester 1.
        a_req_we = 2'b10; a_req_addr[25:13] = 13'h0000; a_req_wmask[15:8] = 8'h0F;
        a_req_wdata[127:64] = 64'hAAAA_BBBB_CCCC_DDDD; a_req_valid = 2'b10;
        #1;
        check("wr_ready", a_req_ready,  2'b10);
        check("wr_en",    a_bram_en,    1'b1);
        check("wr_we",    a_bram_we,    1'b1);
        check("wr_wmask", a_bram_wmask, 8'h0F);
        check("wr_addr",  a_bram_addr,  13'h0000);
        check("wr_wdata", a_bram_wdata, 64'hAAAA_BBBB_CCCC_DDDD);
        @(negedge clk);
        a_req_valid = 2'b00;
        @(negedge clk);
        check("wr_resp_valid", a_resp_valid, 2'b10);
        check("wr_resp_data",  a_resp_rdata, 64'h0);
        a_resp_ready = 2'b10;
        @(negedge clk);
        a_resp_ready = 2'b00;

        // Contention: both requesters continuously valid, expect alternation starting at 0.
        a_req_we = 2'b00; a_req_addr[12:0] = 13'h0100; a_req_addr[25:13] = 13'h0200;
        a_req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            a_slave = 64'h100 + 64'(i);
            #1;
            check("cont_grant", a_req_ready, exp_g);
            check("cont_addr",  a_bram_addr, (i % 2 == 0) ? 13'h0100 : 13'h0200);
            @(negedge clk);
            check("cont_capt_ready", a_req_ready, 2'b00);
            @(negedge clk);
            check("cont_resp_valid", a_resp_valid, exp_g);
            check("cont_resp_data",  a_resp_rdata, 64'h100 + 64'(i));
            check("cont_resp_ready0", a_req_ready, 2'b00);
            a_resp_ready = 2'b11;
            @(negedge clk);
            a_resp_ready = 2'b00;
        end

        // Response backpressure with requester 1 waiting and asserting resp_ready as non-owner.
        a_req_valid = 2'b01; a_req_addr[12:0] = 13'h0040; a_slave = 64'hCAFE;
        #1;
        check("bp_grant", a_req_ready, 2'b01);
        @(negedge clk);
        a_req_valid = 2'b10; a_slave = 64'hBEEF;
        #1;
        check("bp_capt_ready", a_req_ready, 2'b00);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check("bp_hold_valid", a_resp_valid, 2'b01);
            check("bp_hold_data",  a_resp_rdata, 64'hCAFE);
            check("bp_hold_ready", a_req_ready,  2'b00);
            a_resp_ready = 2'b10;
            @(negedge clk);
        end
        check("bp_still_valid", a_resp_valid, 2'b01);
        a_resp_ready = 2'b01;
        @(negedge clk);
        a_resp_ready = 2'b00;
        #1;
        check("bp_next_grant", a_req_ready,  2'b10);
        check("bp_resp_clear", a_resp_valid, 2'b00);
        @(negedge clk);
        a_req_valid = 2'b00;
        @(negedge clk);
        check("bp_r1_valid", a_resp_valid, 2'b10);
        check("bp_r1_data",  a_resp_rdata, 64'hBEEF);
        a_resp_ready = 2'b10;
        @(negedge clk);
        a_resp_ready = 2'b00;

        // ReadLatency=3: data present on bram_rdata_i only at T+3, response at T+4.
        b_slave = 64'h55AA; b_req_addr[12:0] = 13'h0123; b_req_valid = 2'b01;
        #1;
        check("l3_grant", b_req_ready, 2'b01);
        check("l3_en",    b_bram_en,   1'b1);
        @(negedge clk);
        b_req_valid = 2'b00;
        #1;
        check("l3_t1_en",    b_bram_en,    1'b0);
        check("l3_t1_valid", b_resp_valid, 2'b00);
        @(negedge clk);
        check("l3_t2_valid", b_resp_valid, 2'b00);
        @(negedge clk);
        check("l3_t3_valid", b_resp_valid, 2'b00);
        check("l3_t3_ready", b_req_ready,  2'b00);
        @(negedge clk);
        check("l3_t4_valid", b_resp_valid, 2'b01);
        check("l3_t4_data",  b_resp_rdata, 64'h55AA);
        b_resp_ready = 2'b01;
        @(negedge clk);
        b_resp_ready = 2'b00;

        // Reset in WAIT (instance B): pointer returns to favour requester 0.
        b_req_valid = 2'b10;
        #1;
        check("rstw_grant", b_req_ready, 2'b10);
        @(negedge clk);
        b_req_valid = 2'b00; b_rst = 1'b1;
        @(negedge clk);
        check("rstw_valid", b_resp_valid, 2'b00);
        b_rst = 1'b0; b_req_valid = 2'b11;
        #1;
        check("rstw_first_grant", b_req_ready, 2'b01);
        @(negedge clk);
        b_req_valid = 2'b00;

        // Reset in RESP (instance A): pending response dropped.
        a_req_valid = 2'b01; a_slave = 64'h77;
        #1;
        check("rstr_grant", a_req_ready, 2'b01);
        @(negedge clk);
        a_req_valid = 2'b00;
        @(negedge clk);
        check("rstr_pre_valid", a_resp_valid, 2'b01);
        a_rst = 1'b1;
        @(negedge clk);
        check("rstr_valid", a_resp_valid, 2'b00);
        check("rstr_data",  a_resp_rdata, 64'h0);
        a_rst = 1'b0; a_req_valid = 2'b11;
        #1;
        check("rstr_first_grant", a_req_ready, 2'b01);
        @(negedge clk);
        a_req_valid = 2'b00;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
